ir_fetch_ctrl: RTL and testbench
================================

IR_FETCH_CTRL -- requirements
Module: ir_fetch_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: instruction/data word width, same as the decoder datapath.
REQ-002 Parameter IR_ADDR_WIDTH, default 8: instruction address width; irp range 0..2^IR_ADDR_WIDTH-1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 init_req  input  1  request to start a program-load session.
REQ-006 load_len  input  IR_ADDR_WIDTH  number of words to load; sampled with accepted init_req.
REQ-007 load_data  input  DATA_WIDTH  program word offered by the loader.
REQ-008 load_valid  input  1  load_data valid.
REQ-009 load_ready  output  1  block accepts a load word this cycle.
REQ-010 mem_we  output  1  instruction-memory write strobe.
REQ-011 mem_waddr  output  IR_ADDR_WIDTH  instruction-memory write address.
REQ-012 mem_wdata  output  DATA_WIDTH  instruction-memory write data.
REQ-013 load_done  output  1  one-cycle pulse at end of a load session.
REQ-014 run_en  input  1  level; enables instruction fetch.
REQ-015 start_addr  input  IR_ADDR_WIDTH  first fetch address; sampled on IDLE->RUN.
REQ-016 stall  input  1  freeze fetch address this cycle.
REQ-017 br_valid  input  1  redirect fetch to br_target.
REQ-018 br_target  input  IR_ADDR_WIDTH  branch destination.
REQ-019 irp  output  IR_ADDR_WIDTH  instruction fetch pointer to decoder/memory.
REQ-020 fetch_valid  output  1  irp carries a new fetch this cycle.
REQ-021 busy  output  1  high when state is not IDLE.

Function
REQ-022 FSM states IDLE, LOAD, RUN; all outputs registered except load_ready, fetch_valid, busy (decoded from state/inputs).
REQ-023 IDLE: init_req=1 -> LOAD, latch load_len, word counter=0; else run_en=1 -> RUN, irp<=start_addr; init_req has priority over run_en.
REQ-024 IDLE with init_req=1 and load_len=0: no LOAD entry; load_done pulses next cycle, no mem_we.
REQ-025 LOAD: load_ready=1; handshake = load_valid & load_ready; per handshake, next cycle mem_we=1, mem_waddr=counter, mem_wdata=load_data, counter+1.
REQ-026 LOAD: load_valid=0 inserts gaps; mem_we=0 in gap cycles; no timeout.
REQ-027 LOAD: handshake with counter=load_len-1 -> state IDLE, load_done=1 in the same cycle as the final mem_we; load_ready=0 from that cycle.
REQ-028 LOAD ignores init_req, run_en, stall, br_valid.
REQ-029 RUN: fetch_valid = ~stall | br_valid; irp holds its value when stall=1 and br_valid=0.
REQ-030 RUN: br_valid=1 -> irp<=br_target next cycle regardless of stall (branch beats stall).
REQ-031 RUN: no stall, no branch -> irp<=irp+1, modulo 2^IR_ADDR_WIDTH (max wraps to 0, no flag).
REQ-032 RUN with run_en=0 -> IDLE next cycle, irp held at last value, fetch_valid=0 in that cycle; a simultaneous br_valid is dropped.
REQ-033 irp stays unchanged in IDLE and LOAD.

Reset
REQ-034 rst=1 at a clock edge: state=IDLE, irp=0, mem_we=0, mem_waddr=0, mem_wdata=0, load_done=0, counter=0, latched load_len=0.
REQ-035 Reset mid-LOAD or mid-RUN aborts immediately; no load_done pulse; partially loaded memory contents are not cleared.
REQ-036 During and the cycle after reset, load_ready=0, fetch_valid=0, busy=0.

Verification
REQ-037 init_req, load_len=3, words 0xA1,0xB2,0xC3 back-to-back -> mem_we on 3 consecutive cycles at addr 0,1,2 with those data; load_done with third write; busy low after.
REQ-038 load_len=2 with load_valid gap of 2 cycles between words -> exactly 2 writes (addr 0,1), load_done only with second write.
REQ-039 run_en=1, start_addr=0xFD, no stall -> irp 0xFD,0xFE,0xFF,0x00,0x01 on successive cycles, fetch_valid=1 throughout.
REQ-040 RUN irp=0x10, stall=1 two cycles then br_valid=1 br_target=0x40 with stall=1 -> irp 0x10,0x10 then 0x40; fetch_valid 0,0,1.
REQ-041 rst=1 during LOAD after one word -> state IDLE, no load_done, irp=0; subsequent init_req load_len=1 completes normally at addr 0.
REQ-042 init_req and run_en both high in IDLE -> LOAD entered; after load_done with run_en still high, RUN starts at start_addr on the next cycle.

Source files
------------

// File: rtl/ir_fetch_ctrl.sv
// ir_fetch_ctrl: program-load sequencer and instruction fetch pointer controller
module ir_fetch_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int IR_ADDR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_req,
  input  logic [IR_ADDR_WIDTH-1:0] load_len,
  input  logic [DATA_WIDTH-1:0]    load_data,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic                     mem_we,
  output logic [IR_ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     load_done,
  input  logic                     run_en,
  input  logic [IR_ADDR_WIDTH-1:0] start_addr,
  input  logic                     stall,
  input  logic                     br_valid,
  input  logic [IR_ADDR_WIDTH-1:0] br_target,
  output logic [IR_ADDR_WIDTH-1:0] irp,
  output logic                     fetch_valid,
  output logic                     busy
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state, state_nxt;
  logic [IR_ADDR_WIDTH-1:0] cnt, len;
  logic hs, last;
  assign load_ready  = ~rst & (state == LOAD);
  assign busy        = ~rst & (state != IDLE);
  assign fetch_valid = ~rst & (state == RUN) & run_en & (~stall | br_valid);
  assign hs          = load_valid & load_ready;
  assign last        = cnt == len - IR_ADDR_WIDTH'(1);
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (init_req ? (load_len != '0 ? LOAD : IDLE) : (run_en ? RUN : IDLE))
              : state == LOAD ? (hs && last ? IDLE : LOAD)
              : (run_en ? RUN : IDLE);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      irp       <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      load_done <= 1'b0;
      cnt       <= '0;
      len       <= '0;
    end else begin
      mem_we    <= hs;
      load_done <= 1'b0;
      if (hs) begin
        mem_waddr <= cnt;
        mem_wdata <= load_data;
        cnt       <= cnt + IR_ADDR_WIDTH'(1);
        load_done <= last;
      end
      if (state == IDLE && init_req) begin
        len       <= load_len;
        cnt       <= '0;
        load_done <= load_len == '0;
      end
      if (state == IDLE && !init_req && run_en) irp <= start_addr;
      if (state == RUN && run_en) irp <= br_valid ? br_target : (stall ? irp : irp + IR_ADDR_WIDTH'(1));
    end
  end
endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// tb_ir_fetch_ctrl: directed self-checking bench for ir_fetch_ctrl
module tb_ir_fetch_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_req = 1'b0;
  logic [7:0] load_len = '0;
  logic [15:0] load_data = '0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic       load_done;
  logic       run_en = 1'b0;
  logic [7:0] start_addr = '0;
  logic       stall = 1'b0;
  logic       br_valid = 1'b0;
  logic [7:0] br_target = '0;
  logic [7:0] irp;
  logic       fetch_valid;
  logic       busy;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  ir_fetch_ctrl #(.DATA_WIDTH(16), .IR_ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .init_req(init_req), .load_len(load_len),
    .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .load_done(load_done), .run_en(run_en), .start_addr(start_addr),
    .stall(stall), .br_valid(br_valid), .br_target(br_target),
    .irp(irp), .fetch_valid(fetch_valid), .busy(busy)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || load_ready !== 1'b0 || fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_during_comb got=%b%b%b exp=000", busy, load_ready, fetch_valid); end
    step();
    step();
    total++; if (irp !== 8'h00) begin bad++; $display("FAIL rst_irp got=%h exp=00", irp); end
    total++; if (mem_we !== 1'b0 || load_done !== 1'b0) begin bad++; $display("FAIL rst_we_done got=%b%b exp=00", mem_we, load_done); end
    total++; if (mem_waddr !== 8'h00 || mem_wdata !== 16'h0000) begin bad++; $display("FAIL rst_waddr_wdata got=%h/%h exp=00/0000", mem_waddr, mem_wdata); end
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || load_ready !== 1'b0 || fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_after_comb got=%b%b%b exp=000", busy, load_ready, fetch_valid); end
  endtask
  task automatic test_back_to_back();
    logic [15:0] d [3] = '{16'h00A1, 16'h00B2, 16'h00C3};
    init_req = 1'b1; load_len = 8'd3;
    step();
    init_req = 1'b0;
    total++; if (busy !== 1'b1 || load_ready !== 1'b1) begin bad++; $display("FAIL b2b_enter got=%b%b exp=11", busy, load_ready); end
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = d[i];
      step();
      total++; if (mem_we !== 1'b1 || mem_waddr !== 8'(i) || mem_wdata !== d[i]) begin bad++; $display("FAIL b2b_write%0d got=%b/%h/%h exp=1/%h/%h", i, mem_we, mem_waddr, mem_wdata, 8'(i), d[i]); end
      total++; if (load_done !== (i == 2)) begin bad++; $display("FAIL b2b_done%0d got=%b exp=%b", i, load_done, i == 2); end
    end
    load_valid = 1'b0;
    total++; if (busy !== 1'b0 || load_ready !== 1'b0) begin bad++; $display("FAIL b2b_exit got=%b%b exp=00", busy, load_ready); end
    step();
    total++; if (mem_we !== 1'b0 || load_done !== 1'b0) begin bad++; $display("FAIL b2b_after got=%b%b exp=00", mem_we, load_done); end
  endtask
  task automatic test_gap();
    init_req = 1'b1; load_len = 8'd2;
    step();
    init_req = 1'b0; load_valid = 1'b1; load_data = 16'h1111;
    step();
    total++; if (mem_we !== 1'b1 || mem_waddr !== 8'h00 || mem_wdata !== 16'h1111 || load_done !== 1'b0) begin bad++; $display("FAIL gap_w0 got=%b/%h/%h/%b exp=1/00/1111/0", mem_we, mem_waddr, mem_wdata, load_done); end
    load_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (mem_we !== 1'b0 || load_done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL gap_idle%0d got=%b%b%b exp=001", i, mem_we, load_done, busy); end
    end
    load_valid = 1'b1; load_data = 16'h2222;
    step();
    load_valid = 1'b0;
    total++; if (mem_we !== 1'b1 || mem_waddr !== 8'h01 || mem_wdata !== 16'h2222 || load_done !== 1'b1) begin bad++; $display("FAIL gap_w1 got=%b/%h/%h/%b exp=1/01/2222/1", mem_we, mem_waddr, mem_wdata, load_done); end
    step();
    total++; if (mem_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL gap_end got=%b%b exp=00", mem_we, busy); end
  endtask
  task automatic test_zero_len();
    init_req = 1'b1; load_len = 8'd0;
    step();
    init_req = 1'b0;
    total++; if (busy !== 1'b0 || load_done !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL zero_len got=%b%b%b exp=010", busy, load_done, mem_we); end
    step();
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL zero_len_pulse got=%b exp=0", load_done); end
  endtask
  task automatic test_wrap();
    logic [7:0] e [5] = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
    run_en = 1'b1; start_addr = 8'hFD;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (irp !== e[i] || fetch_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL wrap%0d got=%h/%b%b exp=%h/11", i, irp, fetch_valid, busy, e[i]); end
    end
    run_en = 1'b0; br_valid = 1'b1; br_target = 8'h55;
    #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL stop_fv got=%b exp=0", fetch_valid); end
    step();
    br_valid = 1'b0;
    total++; if (busy !== 1'b0 || irp !== 8'h01) begin bad++; $display("FAIL stop_hold got=%b/%h exp=0/01", busy, irp); end
  endtask
  task automatic test_stall_branch();
    run_en = 1'b1; start_addr = 8'h10;
    step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (irp !== 8'h10 || fetch_valid !== 1'b0) begin bad++; $display("FAIL stall%0d got=%h/%b exp=10/0", i, irp, fetch_valid); end
      step();
    end
    br_valid = 1'b1; br_target = 8'h40;
    #1;
    total++; if (irp !== 8'h10 || fetch_valid !== 1'b1) begin bad++; $display("FAIL br_cycle got=%h/%b exp=10/1", irp, fetch_valid); end
    step();
    br_valid = 1'b0; stall = 1'b0;
    total++; if (irp !== 8'h40) begin bad++; $display("FAIL br_target got=%h exp=40", irp); end
    step();
    run_en = 1'b0;
    total++; if (irp !== 8'h41) begin bad++; $display("FAIL br_incr got=%h exp=41", irp); end
    step();
  endtask
  task automatic test_reset_mid_load();
    init_req = 1'b1; load_len = 8'd2;
    step();
    init_req = 1'b0; load_valid = 1'b1; load_data = 16'h0077;
    step();
    load_valid = 1'b0;
    total++; if (mem_we !== 1'b1 || mem_waddr !== 8'h00) begin bad++; $display("FAIL mid_w0 got=%b/%h exp=1/00", mem_we, mem_waddr); end
    rst = 1'b1;
    #1;
    total++; if (load_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_comb got=%b%b exp=00", load_ready, busy); end
    step();
    rst = 1'b0;
    total++; if (busy !== 1'b0 || load_done !== 1'b0 || irp !== 8'h00 || mem_we !== 1'b0) begin bad++; $display("FAIL mid_rst got=%b%b/%h/%b exp=00/00/0", busy, load_done, irp, mem_we); end
    init_req = 1'b1; load_len = 8'd1;
    step();
    init_req = 1'b0; load_valid = 1'b1; load_data = 16'h0099;
    step();
    load_valid = 1'b0;
    total++; if (mem_we !== 1'b1 || mem_waddr !== 8'h00 || mem_wdata !== 16'h0099 || load_done !== 1'b1) begin bad++; $display("FAIL mid_reload got=%b/%h/%h/%b exp=1/00/0099/1", mem_we, mem_waddr, mem_wdata, load_done); end
    step();
  endtask
  task automatic test_priority();
    init_req = 1'b1; run_en = 1'b1; load_len = 8'd1; start_addr = 8'h30;
    step();
    init_req = 1'b0;
    total++; if (busy !== 1'b1 || load_ready !== 1'b1 || fetch_valid !== 1'b0 || irp !== 8'h00) begin bad++; $display("FAIL prio_load got=%b%b%b/%h exp=110/00", busy, load_ready, fetch_valid, irp); end
    load_valid = 1'b1; load_data = 16'h005A;
    step();
    load_valid = 1'b0;
    total++; if (load_done !== 1'b1 || mem_we !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL prio_done got=%b%b%b exp=110", load_done, mem_we, busy); end
    step();
    total++; if (busy !== 1'b1 || irp !== 8'h30 || fetch_valid !== 1'b1) begin bad++; $display("FAIL prio_run got=%b/%h/%b exp=1/30/1", busy, irp, fetch_valid); end
    run_en = 1'b0;
    step();
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_zero_len();
    test_wrap();
    test_stall_branch();
    test_reset_mid_load();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
